// File: rtl/fp_add_preparer_pipe_if.sv
// Handshake bundle between operand issue, the preparer pipe and the adder core.
// master drives operations and consumes results; slave is the preparer itself.
interface fp_add_preparer_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int MW = 2 * MAN_W + 4;

    logic             in_valid;
    logic             in_ready;
    logic [FW-1:0]    op_1;
    logic [FW-1:0]    op_2;
    logic             sub;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             NaN_res;
    logic             inf_res;
    logic             res_sig;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_max;
    logic [MW-1:0]    mant_big;
    logic [MW-1:0]    mant_small;
    logic             sticky;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op_1, op_2, sub, in_tag, out_ready,
        input  in_ready, out_valid, NaN_res, inf_res, res_sig,
        input  eff_sub, exp_max, mant_big, mant_small, sticky, out_tag
    );

    modport slave (
        input  in_valid, op_1, op_2, sub, in_tag, out_ready,
        output in_ready, out_valid, NaN_res, inf_res, res_sig,
        output eff_sub, exp_max, mant_big, mant_small, sticky, out_tag
    );
endinterface

// File: rtl/fp_add_preparer_pipe.sv
// Two-stage elastic FP add operand preparer: decode/order, then align/sticky.
// Stage 1 resolves specials and ordering; stage 2 performs the alignment shift.
module fp_add_preparer_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_add_preparer_pipe_if.slave bus
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int MW = 2 * MAN_W + 4;
    localparam int SW = MAN_W + 1;

    logic             w_s1;
    logic             w_s2;
    logic [EXP_W-1:0] w_e1;
    logic [EXP_W-1:0] w_e2;
    logic [MAN_W-1:0] w_f1;
    logic [MAN_W-1:0] w_f2;
    logic [EXP_W-1:0] w_x1;
    logic [EXP_W-1:0] w_x2;
    logic [SW-1:0]    w_m1;
    logic [SW-1:0]    w_m2;
    logic             w_nan1;
    logic             w_nan2;
    logic             w_inf1;
    logic             w_inf2;
    logic             w_eff_sub;
    logic             w_1big;
    logic             w_equal;
    logic             w_nan;
    logic             w_inf;
    logic             w_sig;
    logic [EXP_W-1:0] w_xbig;
    logic [EXP_W-1:0] w_del;
    logic [SW-1:0]    w_mbig;
    logic [SW-1:0]    w_msmall;

    assign w_s1 = bus.op_1[FW-1];
    assign w_s2 = bus.op_2[FW-1] ^ bus.sub;
    assign w_e1 = bus.op_1[FW-2 -: EXP_W];
    assign w_e2 = bus.op_2[FW-2 -: EXP_W];
    assign w_f1 = bus.op_1[MAN_W-1:0];
    assign w_f2 = bus.op_2[MAN_W-1:0];

    // Denormals share the smallest normal exponent, with no hidden bit.
    assign w_x1 = (w_e1 == '0) ? EXP_W'(1) : w_e1;
    assign w_x2 = (w_e2 == '0) ? EXP_W'(1) : w_e2;
    assign w_m1 = {|w_e1, w_f1};
    assign w_m2 = {|w_e2, w_f2};

    assign w_nan1 = (&w_e1) && (|w_f1);
    assign w_nan2 = (&w_e2) && (|w_f2);
    assign w_inf1 = (&w_e1) && !(|w_f1);
    assign w_inf2 = (&w_e2) && !(|w_f2);

    assign w_eff_sub = w_s1 ^ w_s2;
    assign w_1big    = (w_x1 > w_x2) ||
                       ((w_x1 == w_x2) && (w_m1 >= w_m2));
    assign w_equal   = (w_x1 == w_x2) && (w_m1 == w_m2);

    assign w_nan = w_nan1 || w_nan2 ||
                   (w_inf1 && w_inf2 && w_eff_sub);
    assign w_inf = (w_inf1 || w_inf2) && !w_nan;

    assign w_xbig   = w_1big ? w_x1 : w_x2;
    assign w_del    = w_1big ? (w_x1 - w_x2) : (w_x2 - w_x1);
    assign w_mbig   = w_1big ? w_m1 : w_m2;
    assign w_msmall = w_1big ? w_m2 : w_m1;

    always_comb begin
        w_sig = w_1big ? w_s1 : w_s2;
        if (w_nan) begin
            w_sig = 1'b0;
        end else if (w_inf) begin
            w_sig = w_inf1 ? w_s1 : w_s2;
        end else if (w_eff_sub && w_equal) begin
            w_sig = 1'b0;
        end
    end

    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;

    assign w_adv2       = !r_v2 || bus.out_ready;
    assign w_adv1       = !r_v1 || w_adv2;
    assign bus.in_ready = w_adv1;

    logic             r1_nan;
    logic             r1_inf;
    logic             r1_sig;
    logic             r1_eff_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [EXP_W-1:0] r1_del;
    logic [SW-1:0]    r1_mbig;
    logic [SW-1:0]    r1_msmall;
    logic [TAG_W-1:0] r1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r1_nan     <= 1'b0;
            r1_inf     <= 1'b0;
            r1_sig     <= 1'b0;
            r1_eff_sub <= 1'b0;
            r1_exp     <= '0;
            r1_del     <= '0;
            r1_mbig    <= '0;
            r1_msmall  <= '0;
            r1_tag     <= '0;
        end else if (w_adv1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r1_nan     <= w_nan;
                r1_inf     <= w_inf;
                r1_sig     <= w_sig;
                r1_eff_sub <= w_eff_sub;
                r1_exp     <= w_xbig;
                r1_del     <= w_del;
                r1_mbig    <= w_mbig;
                r1_msmall  <= w_msmall;
                r1_tag     <= r1_tag_next(bus.in_tag);
            end
        end
    end

    function automatic logic [TAG_W-1:0] r1_tag_next(
        input logic [TAG_W-1:0] t
    );
        return t;
    endfunction

    logic [MW-1:0] w_pl_big;
    logic [MW-1:0] w_pl_small;
    logic [MW-1:0] w_shifted;
    logic [MW-1:0] w_lost_mask;
    logic          w_sticky;

    assign w_pl_big   = {1'b0, r1_mbig, {(MAN_W+2){1'b0}}};
    assign w_pl_small = {1'b0, r1_msmall, {(MAN_W+2){1'b0}}};

    // Shifts of MW or more yield zero and an all-ones lost mask.
    assign w_shifted   = w_pl_small >> r1_del;
    assign w_lost_mask = ~({MW{1'b1}} << r1_del);
    assign w_sticky    = |(w_pl_small & w_lost_mask);

    logic             r2_nan;
    logic             r2_inf;
    logic             r2_sig;
    logic             r2_eff_sub;
    logic [EXP_W-1:0] r2_exp;
    logic [MW-1:0]    r2_mbig;
    logic [MW-1:0]    r2_msmall;
    logic             r2_sticky;
    logic [TAG_W-1:0] r2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r2_nan     <= 1'b0;
            r2_inf     <= 1'b0;
            r2_sig     <= 1'b0;
            r2_eff_sub <= 1'b0;
            r2_exp     <= '0;
            r2_mbig    <= '0;
            r2_msmall  <= '0;
            r2_sticky  <= 1'b0;
            r2_tag     <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r2_nan     <= r1_nan;
                r2_inf     <= r1_inf;
                r2_sig     <= r1_sig;
                r2_eff_sub <= r1_eff_sub;
                r2_exp     <= r1_exp;
                r2_mbig    <= w_pl_big;
                r2_msmall  <= w_shifted;
                r2_sticky  <= w_sticky;
                r2_tag     <= r1_tag;
            end
        end
    end

    assign bus.out_valid  = r_v2;
    assign bus.NaN_res    = r2_nan;
    assign bus.inf_res    = r2_inf;
    assign bus.res_sig    = r2_sig;
    assign bus.eff_sub    = r2_eff_sub;
    assign bus.exp_max    = r2_exp;
    assign bus.mant_big   = r2_mbig;
    assign bus.mant_small = r2_msmall;
    assign bus.sticky     = r2_sticky;
    assign bus.out_tag    = r2_tag;
endmodule

// File: tb/tb_fp_add_preparer_pipe.sv
// Randomised scoreboard bench for fp_add_preparer_pipe at FP32 defaults.
// Expected results come from an arithmetic model of the preparer rules.
module tb_fp_add_preparer_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_preparer_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fp_add_preparer_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        nan;
        logic        inf;
        logic        sig;
        logic        es;
        logic [7:0]  em;
        logic [49:0] mb;
        logic [49:0] ms;
        logic        st;
        logic [3:0]  tag;
        int          edge_n;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   acc_last = 0;
    int   checks = 0;
    int   errors = 0;
    int   or_mode = 0;
    int   pat = 0;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic s, logic [3:0] t);
        exp_t   r;
        int     ea, eb, xa, xb, del;
        longint fa, fb, ma, mb, pb, ps, tmp;
        bit     sa, sb, na, nb, ia, ib, abig;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        sa = a[31];
        sb = b[31] ^ s;
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        ma = ((ea == 0) ? 0 : 8388608) + fa;
        mb = ((eb == 0) ? 0 : 8388608) + fb;
        abig = (xa > xb) || ((xa == xb) && (ma >= mb));
        r.es = sa ^ sb;
        if (abig) begin
            r.em = 8'(xa); pb = ma * 33554432; ps = mb * 33554432;
            del = xa - xb;
        end else begin
            r.em = 8'(xb); pb = mb * 33554432; ps = ma * 33554432;
            del = xb - xa;
        end
        r.mb = pb[49:0];
        if (del >= 50) begin
            r.ms = '0;
            r.st = (ps != 0);
        end else begin
            tmp  = ps >> del;
            r.ms = tmp[49:0];
            r.st = ((tmp << del) != ps);
        end
        r.nan = na || nb || (ia && ib && r.es);
        r.inf = (ia || ib) && !r.nan;
        if (r.nan) r.sig = 1'b0;
        else if (r.inf) r.sig = ia ? sa : sb;
        else if (r.es && (xa == xb) && (ma == mb)) r.sig = 1'b0;
        else r.sig = abig ? sa : sb;
        r.tag = t;
        r.edge_n = 0;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                pat++;
            end
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin : mon
        exp_t e;
        bit   ev;
        acc_last = 0;
        if (rst_n) begin
            ev = (q.size() > 0) && (cyc >= q[0].edge_n + 1);
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            chk("in_ready", 64'(bus.in_ready),
                64'(!((q.size() >= 2) && !bus.out_ready)));
            if (q.size() > 2) chk("occupancy", 64'(q.size()), 64'd2);
            if (ev) begin
                chk("NaN_res", 64'(bus.NaN_res), 64'(q[0].nan));
                chk("inf_res", 64'(bus.inf_res), 64'(q[0].inf));
                chk("res_sig", 64'(bus.res_sig), 64'(q[0].sig));
                chk("eff_sub", 64'(bus.eff_sub), 64'(q[0].es));
                chk("exp_max", 64'(bus.exp_max), 64'(q[0].em));
                chk("mant_big", 64'(bus.mant_big), 64'(q[0].mb));
                chk("mant_small", 64'(bus.mant_small), 64'(q[0].ms));
                chk("sticky", 64'(bus.sticky), 64'(q[0].st));
                chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.op_1, bus.op_2, bus.sub, bus.in_tag);
                e.edge_n = cyc + 1;
                q.push_back(e);
                acc_last = 1;
            end
        end
    end

    task automatic send(logic [31:0] a, logic [31:0] b,
                        logic s, logic [3:0] t);
        int n;
        bus.in_valid = 1'b1;
        bus.op_1 = a;
        bus.op_2 = b;
        bus.sub = s;
        bus.in_tag = t;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_last && n < 100);
        if (!acc_last) chk("accept_timeout", 64'(n), 64'd0);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 7))
            0: e = 8'd0;
            1: e = 8'hFF;
            2: e = 8'd1;
            default: e = 8'($urandom_range(0, 255));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [31:0] rnd_pair(logic [31:0] a);
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0: return {1'($urandom), a[30:0]};
            1: begin
                e = a[30:23] + 8'($urandom_range(0, 60)) - 8'd30;
                return {1'($urandom), e, 23'($urandom)};
            end
            default: return rnd_fp();
        endcase
    endfunction

    initial begin : main
        exp_t        e;
        logic [31:0] a;
        bus.in_valid = 1'b0;
        bus.op_1 = '0;
        bus.op_2 = '0;
        bus.sub = 1'b0;
        bus.in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mant_big", 64'(bus.mant_big), 64'd0);
        chk("rst_exp_max", 64'(bus.exp_max), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        e = model(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
        chk("pin1_exp", 64'(e.em), 64'h80);
        chk("pin1_big", 64'(e.mb), 64'h1_0000_0000_0000);
        chk("pin1_small", 64'(e.ms), 64'h0_8000_0000_0000);
        chk("pin1_st", 64'(e.st), 64'd0);
        e = model(32'hC0400000, 32'hC0400000, 1'b1, 4'd2);
        chk("pin2_es", 64'(e.es), 64'd1);
        chk("pin2_sig", 64'(e.sig), 64'd0);
        chk("pin2_eq", 64'(e.ms), 64'(e.mb));
        e = model(32'h7F800000, 32'h7F800000, 1'b1, 4'd3);
        chk("pin3_nan", 64'(e.nan), 64'd1);
        e = model(32'h7F800000, 32'h7F800000, 1'b0, 4'd3);
        chk("pin3_inf", 64'({e.nan, e.inf, e.sig}), 64'b010);
        e = model(32'h4B800000, 32'h00000001, 1'b0, 4'd4);
        chk("pin4", 64'({e.ms, e.st}), 64'd1);
        e = model(32'h4C000000, 32'h3F800001, 1'b0, 4'd5);
        chk("pin5", 64'({e.ms, e.st}), 64'h0_0000_0080_0001 << 1);

        send(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
        send(32'h40400000, 32'h40400000, 1'b1, 4'd2);
        send(32'hC0400000, 32'hC0400000, 1'b1, 4'd3);
        send(32'h7F800000, 32'h7F800000, 1'b1, 4'd4);
        send(32'h7F800000, 32'h7F800000, 1'b0, 4'd5);
        send(32'h7F800000, 32'h7FC00000, 1'b0, 4'd6);
        send(32'h4B800000, 32'h00000001, 1'b0, 4'd7);
        send(32'h4C000000, 32'h3F800001, 1'b0, 4'd8);
        wait_empty();

        or_mode = 1;
        for (int i = 0; i < 8; i++) begin
            a = rnd_fp();
            send(a, rnd_pair(a), 1'($urandom), 4'(i));
        end
        wait_empty();

        or_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                @(posedge clk);
                #1;
            end
            a = rnd_fp();
            send(a, rnd_pair(a), 1'($urandom), 4'($urandom));
        end
        wait_empty();

        or_mode = 3;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd9);
        send(32'h40400000, 32'hC0000000, 1'b0, 4'd10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        or_mode = 0;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd11);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
